// File: rtl/mem_types_pkg.sv
// Shared types for the cache-to-memory burst path.
// Line is a packed array of beats; beat 0 sits in bits [BURST_W-1:0].
package mem_types_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = LINE_W / BURST_W;
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LINE_BYTES = LINE_W / 8;

  typedef logic [ADDR_W-1:0]              addr_t;
  typedef logic [BURST_W-1:0]             burst_t;
  typedef logic [BEATS-1:0][BURST_W-1:0]  line_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_e;

  // Clear the byte-within-line offset bits.
  function automatic addr_t line_align(input addr_t a);
    return a & ~addr_t'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat index within a line burst.
// Ports: clk, rst (sync, active-high), inc_i (advance one beat), clr_i (force 0),
//        cnt_o (registered beat index), last_c (combinational: cnt_o is the final beat).
module beat_counter
  import mem_types_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last_c = (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_o  = cnt_q;

  // Wrap to zero after the final beat so the next burst starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write into BEATS burst beats to memory and
// returns a single line-level response pulse to the cache.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   line_i / line_o          write line from cache / read line to cache
//   address_i, read_i,       line request from cache (held until resp_o)
//   write_i, resp_o
//   burst_i / burst_o        read beat from memory / write beat to memory
//   address_o, read_o,       line-aligned burst request to memory
//   write_o, resp_i          resp_i = one beat accepted/delivered this cycle
module cacheline_adaptor
  import mem_types_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  line_t  line_i,
  output line_t  line_o,
  input  addr_t  address_i,
  input  logic   read_i,
  input  logic   write_i,
  output logic   resp_o,
  input  burst_t burst_i,
  output burst_t burst_o,
  output addr_t  address_o,
  output logic   read_o,
  output logic   write_o,
  input  logic   resp_i
);

  adaptor_state_e   state_q, state_d;
  line_t            line_buf_q, line_buf_d;
  addr_t            address_q, address_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             resp_q, resp_d;

  logic [CNT_W-1:0] cnt;
  logic             cnt_last_c;
  logic             cnt_inc;
  logic             cnt_clr;

  beat_counter u_beat_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .cnt_o  (cnt),
    .last_c (cnt_last_c)
  );

  // Next-state, line buffer and request control.
  always_comb begin
    state_d    = state_q;
    line_buf_d = line_buf_q;
    address_d  = address_q;
    cnt_inc    = 1'b0;
    cnt_clr    = (state_q == IDLE) || (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        // Write wins; a concurrent read stays pending on read_i.
        if (write_i) begin
          line_buf_d = line_i;
          address_d  = line_align(address_i);
          state_d    = WR_BURST;
        end else if (read_i) begin
          address_d  = line_align(address_i);
          state_d    = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          cnt_inc         = 1'b1;
          line_buf_d[cnt] = burst_i;
          if (cnt_last_c) begin
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_inc = 1'b1;
          if (cnt_last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_buf_q <= '0;
      address_q  <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_buf_q <= line_buf_d;
      address_q  <= address_d;
      read_q     <= read_d;
      write_q    <= write_d;
      resp_q     <= resp_d;
    end
  end

  // Write beat selected by the current beat index; quiet outside write bursts.
  assign burst_o   = (state_q == WR_BURST) ? line_buf_q[cnt] : '0;
  assign line_o    = line_buf_q;
  assign address_o = address_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor with a line-granular memory model.
module tb_cacheline_adaptor;
  import mem_types_pkg::*;

  logic   clk;
  logic   rst;
  line_t  line_i;
  line_t  line_o;
  addr_t  address_i;
  logic   read_i;
  logic   write_i;
  logic   resp_o;
  burst_t burst_i;
  burst_t burst_o;
  addr_t  address_o;
  logic   read_o;
  logic   write_o;
  logic   resp_i;

  int checks   = 0;
  int errors   = 0;
  int exp_resp = 0;
  int resp_seen = 0;
  int overlap  = 0;

  line_t mem_model [addr_t];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-run observers: request overlap and total resp_o cycles.
  always @(negedge clk) begin
    if (read_o === 1'b1 && write_o === 1'b1) overlap++;
    if (resp_o === 1'b1) resp_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < int'(BEATS); k++) l[k] = {$urandom, $urandom};
    return l;
  endfunction

  // One full line transaction; g0..g3 are idle cycles before each beat.
  task automatic xact(input bit is_wr, input bit keep_rd, input addr_t a,
                      input line_t wdata, input line_t rdata,
                      input int g0, input int g1, input int g2, input int g3,
                      input addr_t exp_addr, output line_t got_wr);
    int gaps [4];
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    got_wr = '0;
    address_i = a;
    line_i    = wdata;
    write_i   = is_wr;
    read_i    = !is_wr || keep_rd;
    tick();
    line_i = rand_line();
    chk("addr_o", address_o, exp_addr);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < gaps[k]; j++) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        chk("rd_o_held", read_o, !is_wr);
        chk("wr_o_held", write_o, is_wr);
        chk("no_resp_mid", resp_o, 1'b0);
        tick();
      end
      resp_i  = 1'b1;
      burst_i = rdata[k];
      chk("rd_o_beat", read_o, !is_wr);
      chk("wr_o_beat", write_o, is_wr);
      if (is_wr) got_wr[k] = burst_o;
      tick();
    end
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    chk("resp_done", resp_o, 1'b1);
    chk("rd_o_done", read_o, 1'b0);
    chk("wr_o_done", write_o, 1'b0);
    if (!is_wr) chk("line_o", line_o, rdata);
    write_i = 1'b0;
    read_i  = keep_rd;
    exp_resp++;
    tick();
    chk("resp_pulse_end", resp_o, 1'b0);
    chk("rd_o_idle", read_o, 1'b0);
    chk("wr_o_idle", write_o, 1'b0);
    if (is_wr) chk("burst_seq", got_wr, wdata);
  endtask

  initial begin : stim
    line_t l1, l2, got, dummy;
    addr_t a, al;
    bit    w;

    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    tick(); tick();
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_addr_o", address_o, 32'h0);
    chk("rst_line_o", line_o, 256'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    rst = 1'b0;
    tick();

    // 1: read of 0x40, beats on consecutive cycles
    l1[0] = 64'h1111_1111_1111_1111; l1[1] = 64'h2222_2222_2222_2222;
    l1[2] = 64'h3333_3333_3333_3333; l1[3] = 64'h4444_4444_4444_4444;
    xact(1'b0, 1'b0, 32'h0000_0040, '0, l1, 0, 0, 0, 0, 32'h0000_0040, got);

    // 2: write {D,C,B,A} to 0x1234
    l2[0] = 64'hAAAA_AAAA_0000_000A; l2[1] = 64'hBBBB_BBBB_0000_000B;
    l2[2] = 64'hCCCC_CCCC_0000_000C; l2[3] = 64'hDDDD_DDDD_0000_000D;
    xact(1'b1, 1'b0, 32'h0000_1234, l2, rand_line(), 0, 0, 0, 0, 32'h0000_1220, got);
    chk("wr_first_beat", got[0], 64'hAAAA_AAAA_0000_000A);

    // 3: read with resp_i 1,0,0,1,1,0,1
    l1 = rand_line();
    xact(1'b0, 1'b0, 32'h0000_2000, '0, l1, 0, 2, 0, 1, 32'h0000_2000, got);

    // 4: simultaneous read+write: write first, read stays pending
    l2 = rand_line();
    xact(1'b1, 1'b1, 32'h0000_0300, l2, rand_line(), 1, 0, 1, 0, 32'h0000_0300, got);
    xact(1'b0, 1'b0, 32'h0000_0300, '0, got, 0, 1, 0, 0, 32'h0000_0300, dummy);

    // 5: reset after two read beats
    address_i = 32'h0000_0080; read_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      tick();
    end
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    tick();
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_write_o", write_o, 1'b0);
    chk("midrst_resp_o", resp_o, 1'b0);
    chk("midrst_addr_o", address_o, 32'h0);
    chk("midrst_line_o", line_o, 256'h0);
    chk("midrst_burst_o", burst_o, 64'h0);
    rst = 1'b0;
    tick();
    l1 = rand_line();
    xact(1'b0, 1'b0, 32'h0000_0080, '0, l1, 0, 0, 1, 0, 32'h0000_0080, got);

    // 6: spurious resp_i in IDLE, then back-to-back reads
    resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      burst_i = {$urandom, $urandom};
      tick();
      chk("spur_resp_o", resp_o, 1'b0);
      chk("spur_read_o", read_o, 1'b0);
      chk("spur_write_o", write_o, 1'b0);
    end
    resp_i = 1'b0;
    l1 = rand_line(); l2 = rand_line();
    xact(1'b0, 1'b0, 32'h0000_0000, '0, l1, 0, 0, 0, 0, 32'h0000_0000, got);
    xact(1'b0, 1'b0, 32'h0000_0020, '0, l2, 0, 0, 0, 0, 32'h0000_0020, got);

    // Random traffic against a line-addressed memory model
    for (int t = 0; t < 16; t++) begin
      a  = 32'h0000_1000 + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 31));
      al = (a >> 5) << 5;
      w  = 1'($urandom_range(0, 1));
      if (w) begin
        l1 = rand_line();
        xact(1'b1, 1'b0, a, l1, rand_line(), 25, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 2), al, got);
        mem_model[al] = got;
      end else begin
        if (!mem_model.exists(al)) mem_model[al] = rand_line();
        xact(1'b0, 1'b0, a, '0, mem_model[al], 50, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 2), al, got);
      end
    end

    tick();
    chk("rd_wr_overlap", overlap, 0);
    chk("resp_count", resp_seen, exp_resp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
